// File: rtl/biriscv_decode_queue_pkg.sv
// Shared decode constants for the decode queue: class-bit layout and instruction matching helper.
package biriscv_decode_queue_pkg;

    localparam int CLASS_W        = 8;
    localparam int CLASS_INVALID  = 0;
    localparam int CLASS_EXEC     = 1;
    localparam int CLASS_LSU      = 2;
    localparam int CLASS_BRANCH   = 3;
    localparam int CLASS_MUL      = 4;
    localparam int CLASS_DIV      = 5;
    localparam int CLASS_CSR      = 6;
    localparam int CLASS_RD_VALID = 7;

    localparam logic [31:0] MASK_OP   = 32'h0000_007f;
    localparam logic [31:0] MASK_F3   = 32'h0000_707f;
    localparam logic [31:0] MASK_SH   = 32'hfc00_707f;
    localparam logic [31:0] MASK_R    = 32'hfe00_707f;
    localparam logic [31:0] MASK_ALL  = 32'hffff_ffff;
    localparam logic [31:0] MASK_ERET = 32'hcfff_ffff;
    localparam logic [31:0] MASK_WFI  = 32'hffff_8fff;
    localparam logic [31:0] MASK_SFEN = 32'hfe00_7fff;

    function automatic logic f_match(input logic [31:0] instr, input logic [31:0] val,
                                     input logic [31:0] mask);
        return (instr & mask) == val;
    endfunction

endpackage

// File: rtl/biriscv_decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of the decode queue.
interface biriscv_decode_queue_if #(parameter int LANES = 2);
    logic                  fetch_valid_i;
    logic [LANES-1:0]      fetch_lane_valid_i;
    logic [32*LANES-1:0]   fetch_instr_i;
    logic [31:0]           fetch_pc_i;
    logic [LANES-1:0]      fetch_fault_i;
    logic                  fetch_accept_o;
    logic                  out_valid_o;
    logic [31:0]           out_pc_o;
    logic [32*LANES-1:0]   out_instr_o;
    logic [LANES-1:0]      out_lane_valid_o;
    logic [LANES-1:0]      out_fault_o;
    logic [8*LANES-1:0]    out_class_o;
    logic                  out_accept_i;

    modport slave (
        input  fetch_valid_i, fetch_lane_valid_i, fetch_instr_i, fetch_pc_i, fetch_fault_i,
        output fetch_accept_o,
        output out_valid_o, out_pc_o, out_instr_o, out_lane_valid_o, out_fault_o, out_class_o,
        input  out_accept_i
    );

    modport master (
        output fetch_valid_i, fetch_lane_valid_i, fetch_instr_i, fetch_pc_i, fetch_fault_i,
        input  fetch_accept_o,
        input  out_valid_o, out_pc_o, out_instr_o, out_lane_valid_o, out_fault_o, out_class_o,
        output out_accept_i
    );
endinterface

// File: rtl/biriscv_decode_queue_lane.sv
// Single-lane RV32IM/Zicsr classifier; purely combinational.
module biriscv_decode_lane
    import biriscv_decode_queue_pkg::*;
(
    input  logic               i_valid,
    input  logic               i_fault,
    input  logic               i_muldiv_en,
    input  logic [31:0]        i_instr,
    output logic [CLASS_W-1:0] o_class
);
    logic w_alu, w_load, w_store, w_jump, w_bxx, w_mul, w_div, w_csrxx, w_sys, w_known;

    assign w_alu =
        f_match(i_instr, 32'h0000_0013, MASK_F3) | f_match(i_instr, 32'h0000_2013, MASK_F3) |
        f_match(i_instr, 32'h0000_3013, MASK_F3) | f_match(i_instr, 32'h0000_4013, MASK_F3) |
        f_match(i_instr, 32'h0000_6013, MASK_F3) | f_match(i_instr, 32'h0000_7013, MASK_F3) |
        f_match(i_instr, 32'h0000_1013, MASK_SH) | f_match(i_instr, 32'h0000_5013, MASK_SH) |
        f_match(i_instr, 32'h4000_5013, MASK_SH) |
        f_match(i_instr, 32'h0000_0033, MASK_R)  | f_match(i_instr, 32'h4000_0033, MASK_R)  |
        f_match(i_instr, 32'h0000_1033, MASK_R)  | f_match(i_instr, 32'h0000_2033, MASK_R)  |
        f_match(i_instr, 32'h0000_3033, MASK_R)  | f_match(i_instr, 32'h0000_4033, MASK_R)  |
        f_match(i_instr, 32'h0000_5033, MASK_R)  | f_match(i_instr, 32'h4000_5033, MASK_R)  |
        f_match(i_instr, 32'h0000_6033, MASK_R)  | f_match(i_instr, 32'h0000_7033, MASK_R)  |
        f_match(i_instr, 32'h0000_0037, MASK_OP) | f_match(i_instr, 32'h0000_0017, MASK_OP);

    assign w_load =
        f_match(i_instr, 32'h0000_0003, MASK_F3) | f_match(i_instr, 32'h0000_1003, MASK_F3) |
        f_match(i_instr, 32'h0000_2003, MASK_F3) | f_match(i_instr, 32'h0000_4003, MASK_F3) |
        f_match(i_instr, 32'h0000_5003, MASK_F3) | f_match(i_instr, 32'h0000_6003, MASK_F3);

    assign w_store =
        f_match(i_instr, 32'h0000_0023, MASK_F3) | f_match(i_instr, 32'h0000_1023, MASK_F3) |
        f_match(i_instr, 32'h0000_2023, MASK_F3);

    assign w_jump = f_match(i_instr, 32'h0000_006f, MASK_OP) | f_match(i_instr, 32'h0000_0067, MASK_F3);

    assign w_bxx =
        f_match(i_instr, 32'h0000_0063, MASK_F3) | f_match(i_instr, 32'h0000_1063, MASK_F3) |
        f_match(i_instr, 32'h0000_4063, MASK_F3) | f_match(i_instr, 32'h0000_5063, MASK_F3) |
        f_match(i_instr, 32'h0000_6063, MASK_F3) | f_match(i_instr, 32'h0000_7063, MASK_F3);

    // With the M group disabled these encodings fall through to invalid.
    assign w_mul = i_muldiv_en & (
        f_match(i_instr, 32'h0200_0033, MASK_R) | f_match(i_instr, 32'h0200_1033, MASK_R) |
        f_match(i_instr, 32'h0200_2033, MASK_R) | f_match(i_instr, 32'h0200_3033, MASK_R));

    assign w_div = i_muldiv_en & (
        f_match(i_instr, 32'h0200_4033, MASK_R) | f_match(i_instr, 32'h0200_5033, MASK_R) |
        f_match(i_instr, 32'h0200_6033, MASK_R) | f_match(i_instr, 32'h0200_7033, MASK_R));

    assign w_csrxx =
        f_match(i_instr, 32'h0000_1073, MASK_F3) | f_match(i_instr, 32'h0000_2073, MASK_F3) |
        f_match(i_instr, 32'h0000_3073, MASK_F3) | f_match(i_instr, 32'h0000_5073, MASK_F3) |
        f_match(i_instr, 32'h0000_6073, MASK_F3) | f_match(i_instr, 32'h0000_7073, MASK_F3);

    assign w_sys = w_csrxx |
        f_match(i_instr, 32'h0000_0073, MASK_ALL)  | f_match(i_instr, 32'h0010_0073, MASK_ALL) |
        f_match(i_instr, 32'h0020_0073, MASK_ERET) | f_match(i_instr, 32'h1050_0073, MASK_WFI) |
        f_match(i_instr, 32'h0000_000f, MASK_F3)   | f_match(i_instr, 32'h0000_100f, MASK_F3) |
        f_match(i_instr, 32'h1200_0073, MASK_SFEN);

    assign w_known = w_alu | w_load | w_store | w_jump | w_bxx | w_mul | w_div | w_sys;

    always_comb begin
        o_class = '0;
        if (i_valid) begin
            o_class[CLASS_INVALID]  = !w_known;
            o_class[CLASS_EXEC]     = w_alu;
            o_class[CLASS_LSU]      = w_load | w_store;
            o_class[CLASS_BRANCH]   = w_jump | w_bxx;
            o_class[CLASS_MUL]      = w_mul;
            o_class[CLASS_DIV]      = w_div;
            o_class[CLASS_CSR]      = w_sys | !w_known | i_fault;
            o_class[CLASS_RD_VALID] = w_alu | w_load | w_jump | w_csrxx | w_mul | w_div;
        end
    end
endmodule

// File: rtl/biriscv_decode_queue.sv
// Decode stage: classifies each fetched bundle at the write port and buffers it in a DEPTH-entry FIFO.
module biriscv_decode_queue
    import biriscv_decode_queue_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int DEPTH          = 4,
    parameter int SUPPORT_MULDIV = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_muldiv_i,
    input  logic                       flush_i,
    biriscv_decode_queue_if.slave      bus,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [PW-1:0]          r_rd_ptr, r_wr_ptr;
    logic [LW-1:0]          r_level;
    logic [31:0]            r_pc    [DEPTH];
    logic [32*LANES-1:0]    r_instr [DEPTH];
    logic [LANES-1:0]       r_lv    [DEPTH];
    logic [LANES-1:0]       r_fault [DEPTH];
    logic [8*LANES-1:0]     r_class [DEPTH];

    logic                   w_muldiv_en, w_accept, w_push, w_pop, w_valid;
    logic [8*LANES-1:0]     w_class;

    assign w_muldiv_en = (SUPPORT_MULDIV != 0) && enable_muldiv_i;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        biriscv_decode_lane u_lane (
            .i_valid     (bus.fetch_lane_valid_i[g]),
            .i_fault     (bus.fetch_fault_i[g]),
            .i_muldiv_en (w_muldiv_en),
            .i_instr     (bus.fetch_instr_i[32*g +: 32]),
            .o_class     (w_class[CLASS_W*g +: CLASS_W])
        );
    end

    // Acceptance depends only on registered level, so a pop never frees a slot in the same cycle.
    assign w_valid  = (r_level != '0);
    assign w_accept = (r_level != LW'(DEPTH)) && !flush_i;
    assign w_push   = bus.fetch_valid_i && w_accept;
    assign w_pop    = w_valid && bus.out_accept_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc[r_wr_ptr]    <= bus.fetch_pc_i;
            r_instr[r_wr_ptr] <= bus.fetch_instr_i;
            r_lv[r_wr_ptr]    <= bus.fetch_lane_valid_i;
            r_fault[r_wr_ptr] <= bus.fetch_fault_i & bus.fetch_lane_valid_i;
            r_class[r_wr_ptr] <= w_class;
        end
    end

    assign bus.fetch_accept_o   = w_accept;
    assign bus.out_valid_o      = w_valid;
    assign bus.out_pc_o         = w_valid ? r_pc[r_rd_ptr]    : '0;
    assign bus.out_instr_o      = w_valid ? r_instr[r_rd_ptr] : '0;
    assign bus.out_lane_valid_o = w_valid ? r_lv[r_rd_ptr]    : '0;
    assign bus.out_fault_o      = w_valid ? r_fault[r_rd_ptr] : '0;
    assign bus.out_class_o      = w_valid ? r_class[r_rd_ptr] : '0;
    assign level_o              = r_level;
endmodule
